// File: rtl/bp_snd_pkg.sv
// Shared types and constants for the sound-command latch.
// Holds the NMI sequencer state encoding, FIFO depth and default NMI width.
// Optional FIFO mode is selected elsewhere with BP_SNDLATCH_FIFO_EN.
package bp_snd_pkg;

  // Sound-CPU handshake sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NMI     = 2'd1,
    WAIT_RD = 2'd2
  } snd_state_t;

  // Entries held when the FIFO option is built in
  localparam int unsigned FIFO_DEPTH    = 4;

  // Default NMI low time in clk_49m cycles
  localparam int unsigned NMI_WIDTH_DEF = 64;

endpackage

// File: rtl/bp_edge_det.sv
// Rising-edge detector for a level strobe: one-cycle pulse on the first high cycle.
// Latency: pulse is combinational with the first sampled-high cycle; no backpressure.
// The detector only arms after it has seen the input low, so a strobe held high through reset is ignored.
module bp_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_arm;

  // Remember last input level; arm once the strobe has been observed low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      r_arm  <= 1'b0;
    end else begin
      r_prev <= i_sig;
      if (!i_sig) begin
        r_arm <= 1'b1;
      end
    end
  end

  assign o_rise = i_sig & ~r_prev & r_arm;

endmodule

// File: rtl/bp_sound_latch.sv
// Main-CPU to sound-CPU command latch with NMI handshake (single register, or 4-entry FIFO).
// Latency: written byte on snd_dout 1 cycle after the main_wr edge; NMI falls the cycle after pending rises.
// Backpressure: none; overwrite (latch) or drop when full (FIFO, macro BP_SNDLATCH_FIFO_EN) sets sticky overflow.
module bp_sound_latch
  import bp_snd_pkg::*;
#(
  parameter int unsigned NMI_WIDTH = NMI_WIDTH_DEF
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       snd_rd,
  output logic [7:0] snd_dout,
  output logic       snd_nmi_n,
  output logic       pending,
  output logic       overflow
);

  localparam logic [7:0] NMI_LOAD = 8'(NMI_WIDTH);

  logic w_wr_rise;
  logic w_rd_rise;
  logic w_pop;
  logic w_push;
  logic w_ovf_evt;
  logic w_restart;
  logic w_pending;

  snd_state_t r_state;
  logic [7:0] r_cnt;
  logic       r_nmi_n;
  logic       r_popped;
  logic       r_ovf;

  bp_edge_det u_wr_edge (
    .i_clk  (clk_49m),
    .i_rst  (reset),
    .i_sig  (main_wr),
    .o_rise (w_wr_rise)
  );

  bp_edge_det u_rd_edge (
    .i_clk  (clk_49m),
    .i_rst  (reset),
    .i_sig  (snd_rd),
    .o_rise (w_rd_rise)
  );

`ifdef BP_SNDLATCH_FIFO_EN

  localparam logic [2:0] FULL_CNT = 3'(FIFO_DEPTH);

  logic [7:0] r_mem [FIFO_DEPTH];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic [7:0] r_last;
  logic       w_full;

  assign w_pending = (r_count != 3'd0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_pop     = w_rd_rise & w_pending;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands
  assign w_push    = w_wr_rise & (~w_full | w_pop);
  assign w_ovf_evt = w_wr_rise & ~w_push;
  assign w_restart = w_pop & w_push;

  // FIFO storage, pointers and occupancy; pop is applied before push
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= 8'h00;
      end
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
      r_last   <= 8'h00;
    end else begin
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= main_din;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry while non-empty, otherwise the most recently popped byte
  assign snd_dout = w_pending ? r_mem[r_rd_ptr] : r_last;

`else

  logic [7:0] r_data;
  logic       r_full;

  assign w_pending = r_full;
  assign w_pop     = w_rd_rise & r_full;
  assign w_push    = w_wr_rise;
  // Writing over an unread byte without a same-cycle pop loses the old command
  assign w_ovf_evt = w_wr_rise & r_full & ~w_pop;
  assign w_restart = w_ovf_evt | (w_pop & w_push);

  // Single holding register; the byte stays visible after it has been read
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      r_data <= 8'h00;
      r_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_data <= main_din;
        r_full <= 1'b1;
      end else if (w_pop) begin
        r_full <= 1'b0;
      end
    end
  end

  assign snd_dout = r_data;

`endif

  // Sticky overflow: cleared only by reset
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_evt) begin
      r_ovf <= 1'b1;
    end
  end

  // NMI sequencer: one full-width pulse per command, then wait for the sound CPU to read it
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 8'd0;
      r_nmi_n  <= 1'b1;
      r_popped <= 1'b0;
    end else if (w_restart) begin
      // Replaced or freshly re-queued command: start a new pulse from full width
      r_state  <= NMI;
      r_cnt    <= NMI_LOAD;
      r_nmi_n  <= 1'b0;
      r_popped <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pending) begin
            r_state  <= NMI;
            r_cnt    <= NMI_LOAD;
            r_nmi_n  <= 1'b0;
            r_popped <= w_pop;
          end
        end
        NMI: begin
          if (w_pop) begin
            r_popped <= 1'b1;
          end
          if (r_cnt <= 8'd1) begin
            // Pulse complete; skip the read wait if the command was already taken
            r_cnt   <= 8'd0;
            r_nmi_n <= 1'b1;
            r_state <= (r_popped | w_pop) ? IDLE : WAIT_RD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        WAIT_RD: begin
          if (w_pop) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 8'd0;
          r_nmi_n <= 1'b1;
        end
      endcase
    end
  end

  assign snd_nmi_n = r_nmi_n;
  assign pending   = w_pending;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_bp_sound_latch.sv
// Directed bench for bp_sound_latch: reset, single write, held strobes, overwrite,
// empty pop, simultaneous pop+write, reset mid-NMI, strobe held through reset.
// FIFO-mode scenario is compiled when BP_SNDLATCH_FIFO_EN is defined.
module tb_bp_sound_latch;

  logic       clk_49m;
  logic       reset;
  logic       main_wr;
  logic [7:0] main_din;
  logic       snd_rd;
  logic [7:0] snd_dout;
  logic       snd_nmi_n;
  logic       pending;
  logic       overflow;

  int n_tests;
  int n_fail;
  int low_cycles;
  int nmi_pulses;
  logic prev_nmi;

  bp_sound_latch #(.NMI_WIDTH(64)) dut (
    .clk_49m   (clk_49m),
    .reset     (reset),
    .main_wr   (main_wr),
    .main_din  (main_din),
    .snd_rd    (snd_rd),
    .snd_dout  (snd_dout),
    .snd_nmi_n (snd_nmi_n),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk_49m = 1'b0;
  always #10 clk_49m = ~clk_49m;

  // Advance one clock and sample 1 time unit after the edge; track NMI activity
  task automatic tick();
    @(posedge clk_49m);
    #1;
    if (snd_nmi_n === 1'b0) low_cycles++;
    if (prev_nmi === 1'b1 && snd_nmi_n === 1'b0) nmi_pulses++;
    prev_nmi = snd_nmi_n;
  endtask

  task automatic clr();
    low_cycles = 0;
    nmi_pulses = 0;
    prev_nmi   = snd_nmi_n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_pulse();
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
    tick();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    main_wr  = 1'b0;
    main_din = 8'h00;
    snd_rd   = 1'b0;
    prev_nmi = 1'b1;
    clr();

    // Reset state
    repeat (3) @(posedge clk_49m);
    #1;
    check("rst_dout", {24'h0, snd_dout}, 32'h00);
    check("rst_nmi",  {31'h0, snd_nmi_n}, 32'h1);
    check("rst_pend", {31'h0, pending},   32'h0);
    check("rst_ovf",  {31'h0, overflow},  32'h0);
    reset = 1'b0;
    tick();
    tick();

    // Single write of 5A: visible next cycle, 64-cycle NMI, read clears pending
    clr();
    main_din = 8'h5A;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    check("wr_dout", {24'h0, snd_dout}, 32'h5A);
    check("wr_pend", {31'h0, pending},  32'h1);
    repeat (100) tick();
    check("wr_nmi_low",    low_cycles, 64);
    check("wr_nmi_pulses", nmi_pulses, 1);
    check("wr_nmi_done",   {31'h0, snd_nmi_n}, 32'h1);
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
    check("pop_pend",  {31'h0, pending},  32'h0);
    check("pop_hold",  {24'h0, snd_dout}, 32'h5A);
    tick();

    // Held main_wr for 10 cycles (data changes after the first), then held snd_rd
    clr();
    main_din = 8'h21;
    main_wr  = 1'b1;
    tick();
    main_din = 8'h33;
    repeat (9) tick();
    main_wr = 1'b0;
    tick();
    check("held_dout", {24'h0, snd_dout}, 32'h21);
    check("held_pend", {31'h0, pending},  32'h1);
    repeat (80) tick();
    snd_rd = 1'b1;
    repeat (10) tick();
    check("held_pop_pend", {31'h0, pending}, 32'h0);
    check("held_nmi_low",    low_cycles, 64);
    check("held_nmi_pulses", nmi_pulses, 1);
    // snd_rd still high: a new command must not be consumed by the held level
    main_din = 8'h44;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    repeat (3) tick();
    check("held_rd_once_pend", {31'h0, pending},  32'h1);
    check("held_rd_once_dout", {24'h0, snd_dout}, 32'h44);
    snd_rd = 1'b0;
    repeat (80) tick();
    pop_pulse();
    check("held_final_pend", {31'h0, pending}, 32'h0);

`ifndef BP_SNDLATCH_FIFO_EN
    // Overwrite of unread byte restarts the NMI
    clr();
    main_din = 8'h01;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    tick();
    repeat (10) tick();
    main_din = 8'h02;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    check("ow_dout", {24'h0, snd_dout},  32'h02);
    check("ow_ovf",  {31'h0, overflow},  32'h1);
    check("ow_nmi",  {31'h0, snd_nmi_n}, 32'h0);
    repeat (100) tick();
    check("ow_nmi_low",    low_cycles, 75);
    check("ow_nmi_pulses", nmi_pulses, 1);
    pop_pulse();
    check("ow_pop_pend",   {31'h0, pending},  32'h0);
    check("ow_ovf_sticky", {31'h0, overflow}, 32'h1);

    // Pop while empty changes nothing
    snd_rd = 1'b1;
    tick();
    snd_rd = 1'b0;
    tick();
    check("emp_dout", {24'h0, snd_dout},  32'h02);
    check("emp_pend", {31'h0, pending},   32'h0);
    check("emp_nmi",  {31'h0, snd_nmi_n}, 32'h1);
`else
    // FIFO: five writes, fifth dropped; four reads in order, four NMI pulses
    clr();
    for (int i = 0; i < 5; i++) begin
      main_din = 8'h10 + 8'(i);
      main_wr  = 1'b1;
      tick();
      main_wr  = 1'b0;
      tick();
    end
    check("ff_ovf",  {31'h0, overflow},  32'h1);
    check("ff_pend", {31'h0, pending},   32'h1);
    for (int i = 0; i < 4; i++) begin
      repeat (80) tick();
      check("ff_dout", {24'h0, snd_dout}, 32'h10 + 32'(i));
      pop_pulse();
    end
    repeat (80) tick();
    check("ff_nmi_pulses", nmi_pulses, 4);
    check("ff_end_pend",   {31'h0, pending},  32'h0);
    check("ff_end_dout",   {24'h0, snd_dout}, 32'h13);
`endif

    // Reset, then one entry waiting, then pop and write edges in the same cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    main_din = 8'h66;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    repeat (80) tick();
    clr();
    main_din = 8'h77;
    main_wr  = 1'b1;
    snd_rd   = 1'b1;
    tick();
    main_wr  = 1'b0;
    snd_rd   = 1'b0;
    check("sim_pend", {31'h0, pending},   32'h1);
    check("sim_dout", {24'h0, snd_dout},  32'h77);
    check("sim_nmi",  {31'h0, snd_nmi_n}, 32'h0);
    check("sim_ovf",  {31'h0, overflow},  32'h0);
    repeat (80) tick();
    check("sim_nmi_low",    low_cycles, 64);
    check("sim_nmi_pulses", nmi_pulses, 1);

    // Reset about 20 cycles into an NMI pulse
    pop_pulse();
    main_din = 8'h88;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    tick();
    main_din = 8'h99;
    main_wr  = 1'b1;
    tick();
    main_wr  = 1'b0;
    repeat (19) tick();
    check("pre_rst_nmi", {31'h0, snd_nmi_n}, 32'h0);
`ifndef BP_SNDLATCH_FIFO_EN
    check("pre_rst_ovf", {31'h0, overflow},  32'h1);
`endif
    reset = 1'b1;
    #1;
    check("mid_rst_nmi",  {31'h0, snd_nmi_n}, 32'h1);
    check("mid_rst_pend", {31'h0, pending},   32'h0);
    check("mid_rst_ovf",  {31'h0, overflow},  32'h0);
    check("mid_rst_dout", {24'h0, snd_dout},  32'h00);

    // main_wr held high across reset release must not be captured
    main_din = 8'hAB;
    main_wr  = 1'b1;
    @(posedge clk_49m);
    #1;
    reset = 1'b0;
    prev_nmi = snd_nmi_n;
    repeat (4) tick();
    check("wr_thru_rst_pend", {31'h0, pending},  32'h0);
    check("wr_thru_rst_dout", {24'h0, snd_dout}, 32'h00);
    main_wr = 1'b0;
    tick();
    // A genuine edge after the strobe drops is captured again
    main_wr = 1'b1;
    tick();
    main_wr = 1'b0;
    check("rearm_dout", {24'h0, snd_dout}, 32'hAB);
    check("rearm_pend", {31'h0, pending},  32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_sound_latch.md
BP_SOUND_LATCH -- requirements
Module: bp_sound_latch

Interface
REQ-001 SHALL have parameter NMI_WIDTH, default 64, giving the sound-CPU NMI low time in clk_49m cycles (range 1..255).
REQ-002 SHALL have port clk_49m, input, 1, the single clock (49.152 MHz).
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port main_wr, input, 1, main-CPU sound-data chip select (level; may span several cycles).
REQ-005 SHALL have port main_din, input, 8, command byte from main CPU data bus.
REQ-006 SHALL have port snd_rd, input, 1, sound-CPU latch read strobe (level).
REQ-007 SHALL have port snd_dout, output, 8, command byte presented to the sound CPU.
REQ-008 SHALL have port snd_nmi_n, output, 1, active-low NMI to the sound Z80.
REQ-009 SHALL have port pending, output, 1, high while at least one unread command is held.
REQ-010 SHALL have port overflow, output, 1, sticky flag for a dropped or overwritten command.

Function
REQ-011 SHALL capture main_din on the rising edge of main_wr (registered edge detect); the stored byte is visible on snd_dout 1 cycle after the edge.
REQ-012 SHALL pop on the rising edge of snd_rd; level held high SHALL pop exactly once.
REQ-013 SHALL drive snd_dout from the head entry; when empty, snd_dout SHALL hold the last popped value.
REQ-014 SHALL run FSM IDLE -> NMI -> WAIT_RD: IDLE to NMI when pending=1; NMI holds snd_nmi_n=0 for exactly NMI_WIDTH cycles, then goes to WAIT_RD; WAIT_RD on pop returns to IDLE (re-entering NMI next cycle if still pending).
REQ-015 SHALL, on pop during NMI, finish the NMI pulse at full width, then go to IDLE.
REQ-016 SHALL, in single-latch mode, overwrite an unread byte on write, set overflow, and restart the FSM to NMI with the counter reloaded.
REQ-017 SHALL, on simultaneous write and pop edges, perform the pop first and then the write; pending stays 1 and a fresh NMI is issued.
REQ-018 SHALL ignore a pop edge when empty (no state or output change).
REQ-019 SHALL use an 8-bit NMI down-counter; NMI_WIDTH=1 gives a one-cycle pulse.

Reset
REQ-020 SHALL on reset force snd_dout=8'h00, snd_nmi_n=1, pending=0, overflow=0, FSM=IDLE, counter=0, storage empty, and edge-detect registers to 0, so that a main_wr held high through reset release is not captured.
REQ-021 SHALL abort any in-progress NMI immediately on reset assertion (snd_nmi_n=1 asynchronously).

Configuration
REQ-022 SHALL, with macro BP_SNDLATCH_FIFO_EN defined, replace the single latch with a 4-entry FIFO (2-bit pointers, 3-bit count); FSM cycles once per entry.
REQ-023 SHALL, with BP_SNDLATCH_FIFO_EN defined, drop a write to a full FIFO (count=4), leave contents unchanged, and set overflow; a simultaneous pop and write when full SHALL both succeed.
REQ-024 SHALL, without BP_SNDLATCH_FIFO_EN, implement exactly one 8-bit holding register with the REQ-016 overwrite semantics.

Structure
REQ-025 SHALL place FSM state typedef (IDLE/NMI/WAIT_RD), FIFO depth constant (4) and NMI_WIDTH default in shared package bp_snd_pkg.
REQ-026 SHALL implement edge detection in one sub-module bp_edge_det (registered input, rise pulse output), instantiated twice.

Verification
REQ-027 Single write: main_wr pulse with 8'h5A -> snd_dout=8'h5A next cycle, pending=1, snd_nmi_n low for exactly 64 cycles; snd_rd pulse -> pending=0.
REQ-028 Held strobes: main_wr high for 10 cycles with 8'h21, then snd_rd high for 10 cycles -> exactly one capture, exactly one pop, one NMI pulse.
REQ-029 Latch mode: write 8'h01 then 8'h02 before read -> snd_dout=8'h02, overflow=1, NMI counter restarted at the second write.
REQ-030 FIFO mode: write 8'h10..8'h14 with no reads -> fifth write dropped, overflow=1; four reads return 8'h10..8'h13; four NMI pulses total.
REQ-031 Simultaneous: empty-to-one state then pop+write edges in the same cycle with 8'h77 -> pending=1, snd_dout=8'h77, new NMI issued.
REQ-032 Reset mid-NMI at cycle 20 of the pulse -> snd_nmi_n=1 immediately, pending=0, overflow=0, snd_dout=8'h00.
